// File: rtl/regfile_pkg.sv
// Shared defaults and write-source encoding for the register-file write-port arbiter.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_MD
  } src_t;
endpackage

// File: rtl/md_result_fifo.sv
// Show-ahead sync FIFO for mult/div results; head visible the cycle after push.
// Backpressure via count: push ignored when full, pop ignored when empty.
module md_result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         ctrl_reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  output logic [WIDTH-1:0]             headData,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign doPush   = push && (count != FULL_CNT);
  assign doPop    = pop && (count != '0);
  assign headData = mem[rdPtr];

  // Storage is not reset; pointers and count alone define validity.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between W-stage writeback and buffered mult/div results.
// Write-out registered (WB: 1 cycle, MD: 2 cycles from accept); md_ready drops when buffer full.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_AW     = REG_AW_DEF,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              md_valid,
  input  logic [REG_AW-1:0] md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  input  logic              md_issue_valid,
  input  logic [REG_AW-1:0] md_issue_rd,
  input  logic [REG_AW-1:0] ctrl_readRegA,
  input  logic [REG_AW-1:0] ctrl_readRegB,
  output logic              busy_a,
  output logic              busy_b,
  output logic              wb_stall,
  output logic              ctrl_writeEnable,
  output logic [REG_AW-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic              md_pending
);
  localparam int NREG     = 2 ** REG_AW;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]    FULL_CNT    = CNT_W'(FIFO_DEPTH);
  localparam logic [STARVE_W-1:0] STARVE_TRIG = STARVE_W'(STARVE_MAX - 1);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } mdEntry_t;

  mdEntry_t             pushEntry;
  mdEntry_t             headEntry;
  logic [CNT_W-1:0]     fifoCount;
  logic                 fifoNonEmpty;
  logic                 push;
  logic                 pop;
  src_t                 src;
  src_t                 outSrc;
  logic [STARVE_W-1:0]  starveCnt;
  logic [NREG-1:0]      sb;
  logic [NREG-1:0]      sbNext;

  assign fifoNonEmpty = (fifoCount != '0);
  assign md_ready     = (fifoCount != FULL_CNT);
  assign push         = md_valid && md_ready && (md_rd != '0);
  assign pushEntry    = '{rd: md_rd, data: md_data};

  md_result_fifo #(
    .WIDTH ($bits(mdEntry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .push         (push),
    .pushData     (pushEntry),
    .pop          (pop),
    .headData     (headEntry),
    .count        (fifoCount)
  );

  // W stage is frozen while wb_stall is high, so its request is ignored then.
  always_comb begin
    src = SRC_NONE;
    if (wb_stall && fifoNonEmpty)                   src = SRC_MD;
    else if (!wb_stall && wb_valid && wb_rd != '0)  src = SRC_WB;
    else if (fifoNonEmpty)                          src = SRC_MD;
  end

  assign pop = (src == SRC_MD);

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      outSrc           <= SRC_NONE;
    end else begin
      ctrl_writeEnable <= (src != SRC_NONE);
      outSrc           <= src;
      if (src == SRC_WB) begin
        ctrl_writeReg <= wb_rd;
        data_writeReg <= wb_data;
      end else if (src == SRC_MD) begin
        ctrl_writeReg <= headEntry.rd;
        data_writeReg <= headEntry.data;
      end
    end
  end

  // Counts consecutive cycles a buffered result lost the port; the stall slot pops it.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      starveCnt <= '0;
      wb_stall  <= 1'b0;
    end else begin
      wb_stall <= 1'b0;
      if (!fifoNonEmpty || pop) begin
        starveCnt <= '0;
      end else begin
        starveCnt <= starveCnt + 1'b1;
        if (starveCnt == STARVE_TRIG) wb_stall <= 1'b1;
      end
    end
  end

  // Clear lands on the edge where the regfile commits the MD write; a fresh issue wins.
  always_comb begin
    sbNext = sb;
    if (ctrl_writeEnable && outSrc == SRC_MD) sbNext[ctrl_writeReg] = 1'b0;
    if (md_issue_valid) sbNext[md_issue_rd] = 1'b1;
    sbNext[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) sb <= '0;
    else               sb <= sbNext;
  end

  assign busy_a     = sb[ctrl_readRegA];
  assign busy_b     = sb[ctrl_readRegB];
  assign md_pending = (sb != '0) || fifoNonEmpty;
endmodule
